// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: sole source of latch enables/flushes for the 5-stage core.
// Optional freeze/bubble cycle counter enabled by macro HAZARD_STALL_CNT_EN.
//
// state  | meaning
// RUN    | normal issue
// DRAIN  | halt seen in ID, fetch stopped, waiting for halt to reach exmem
// HALTED | core stopped, every enable low until nRst
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_pcsrc,
  input  logic             mem_halt,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_flush,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             memwb_flush,
  output logic             halt
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state_q, state_d;
  logic   memstall;
  logic   lduse;

  always_comb begin
    memstall = mem_req & ~dhit;
    lduse    = ex_memread && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  always_comb begin
    state_d     = state_q;
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    ifid_flush  = 1'b0;
    idex_wen    = 1'b0;
    idex_flush  = 1'b0;
    exmem_wen   = 1'b0;
    memwb_wen   = 1'b0;
    memwb_flush = 1'b0;
    // Enables are forced low while reset is asserted, not just after the edge.
    if (nRst && (state_q != HALTED)) begin
      if (memstall) begin
        memwb_wen   = 1'b1;
        memwb_flush = 1'b1;
      end else if (ex_pcsrc) begin
        pc_wen     = 1'b1;
        ifid_wen   = 1'b1;
        ifid_flush = 1'b1;
        idex_wen   = 1'b1;
        idex_flush = 1'b1;
        exmem_wen  = 1'b1;
        memwb_wen  = 1'b1;
      end else if (lduse) begin
        idex_wen   = 1'b1;
        idex_flush = 1'b1;
        exmem_wen  = 1'b1;
        memwb_wen  = 1'b1;
      end else if (!ihit || (state_q == DRAIN)) begin
        ifid_wen   = 1'b1;
        ifid_flush = 1'b1;
        idex_wen   = 1'b1;
        exmem_wen  = 1'b1;
        memwb_wen  = 1'b1;
      end else begin
        pc_wen    = 1'b1;
        ifid_wen  = 1'b1;
        idex_wen  = 1'b1;
        exmem_wen = 1'b1;
        memwb_wen = 1'b1;
      end

      if (state_q == RUN) begin
        if (id_halt && !memstall && !ex_pcsrc && !lduse) state_d = DRAIN;
      end else if (!memstall) begin
        // A redirect while draining means the halt was on the wrong path.
        if (mem_halt)      state_d = HALTED;
        else if (ex_pcsrc) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign halt = (state_q == HALTED);

`ifdef HAZARD_STALL_CNT_EN
  logic             stall_evt;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stall_evt = (state_q != HALTED) &&
                (memstall || (!ex_pcsrc && (lduse || !ihit || (state_q == DRAIN))));
    cnt_d = cnt_q;
    if (stall_evt && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cycles = cnt_q;
`endif

endmodule
